// File: rtl/vector_lane_sequencer_if.sv
// Bus between the execute-stage control unit and the vector lane sequencer.
// The master side owns start/flush, the operands and the lane ALU results.
interface vector_lane_sequencer_if #(
  parameter int unsigned V     = 20,
  parameter int unsigned LANES = 4,
  parameter int unsigned L     = 8
);
  logic                 start_i;
  logic                 flush_i;
  logic [1:0]           op_type_i;
  logic [V*L-1:0]       rd1_vec_i;
  logic [V*L-1:0]       rd2_vec_i;
  logic [L-1:0]         scalar_i;
  logic [LANES*L-1:0]   lane_a_o;
  logic [LANES*L-1:0]   lane_b_o;
  logic [LANES*L-1:0]   lane_result_i;
  logic [V*L-1:0]       result_vec_o;
  logic [2:0]           chunk_o;
  logic                 busy_o;
  logic                 done_o;

  modport master (
    output start_i, flush_i, op_type_i, rd1_vec_i, rd2_vec_i, scalar_i, lane_result_i,
    input  lane_a_o, lane_b_o, result_vec_o, chunk_o, busy_o, done_o
  );

  modport slave (
    input  start_i, flush_i, op_type_i, rd1_vec_i, rd2_vec_i, scalar_i, lane_result_i,
    output lane_a_o, lane_b_o, result_vec_o, chunk_o, busy_o, done_o
  );
endinterface

// File: rtl/vector_lane_sequencer.sv
// Walks one V-element vector op through LANES parallel lane ALUs, one chunk per
// cycle, and gathers the lane results into a full result vector.
module vector_lane_sequencer #(
  parameter int unsigned V     = 20,
  parameter int unsigned LANES = 4,
  parameter int unsigned L     = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  vector_lane_sequencer_if.slave  bus
);

  localparam int unsigned NCHUNK = (V + LANES - 1) / LANES;
  localparam logic [2:0]  LAST   = 3'(NCHUNK - 1);

  if (NCHUNK > 8) begin : g_nchunk_check
    $error("vector_lane_sequencer: NCHUNK exceeds the 3-bit chunk index");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       chunk_q, chunk_d;
  logic [V*L-1:0]   a_q, a_d;
  logic [V*L-1:0]   b_q, b_d;
  logic [L-1:0]     scalar_q, scalar_d;
  logic [1:0]       op_q, op_d;
  logic [V*L-1:0]   result_q, result_d;
  logic [LANES*L-1:0] lane_a, lane_b;
  logic             is_vector_op;

  assign is_vector_op = (bus.op_type_i == 2'b01) || (bus.op_type_i == 2'b10);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      chunk_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      scalar_q <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      chunk_q  <= chunk_d;
      a_q      <= a_d;
      b_q      <= b_d;
      scalar_q <= scalar_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    int unsigned e;
    state_d  = state_q;
    chunk_d  = chunk_q;
    a_d      = a_q;
    b_d      = b_q;
    scalar_d = scalar_q;
    op_d     = op_q;
    result_d = result_q;
    e        = 0;
    case (state_q)
      IDLE: begin
        // flush in IDLE masks a coincident start
        if (bus.start_i && !bus.flush_i) begin
          if (is_vector_op) begin
            a_d      = bus.rd1_vec_i;
            b_d      = bus.rd2_vec_i;
            scalar_d = bus.scalar_i;
            op_d     = bus.op_type_i;
            chunk_d  = '0;
            state_d  = RUN;
          end else begin
            state_d  = DONE;
          end
        end
      end
      RUN: begin
        if (bus.flush_i) begin
          state_d = IDLE;
          chunk_d = '0;
        end else begin
          for (int unsigned j = 0; j < LANES; j++) begin
            e = LANES * 32'(chunk_q) + j;
            if (e < V) begin
              result_d[e*L +: L] = bus.lane_result_i[j*L +: L];
            end
          end
          if (chunk_q == LAST) begin
            state_d = DONE;
          end else begin
            chunk_d = chunk_q + 3'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        chunk_d = '0;
      end
      default: begin
        state_d = IDLE;
        chunk_d = '0;
      end
    endcase
  end

  always_comb begin
    int unsigned e;
    lane_a = '0;
    lane_b = '0;
    e      = 0;
    if (state_q == RUN) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        e = LANES * 32'(chunk_q) + j;
        if (e < V) begin
          lane_a[j*L +: L] = a_q[e*L +: L];
          lane_b[j*L +: L] = (op_q == 2'b10) ? scalar_q : b_q[e*L +: L];
        end
      end
    end
  end

  assign bus.lane_a_o     = lane_a;
  assign bus.lane_b_o     = lane_b;
  assign bus.result_vec_o = result_q;
  assign bus.chunk_o      = chunk_q;
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.done_o       = (state_q == DONE);

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Directed bench for vector_lane_sequencer: a default V=20 instance and a
// V=18 instance whose last chunk is only partly populated.
module tb_vector_lane_sequencer;
  logic CLK = 1'b0;
  logic RST;
  int   errors = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;

  vector_lane_sequencer_if #(.V(20), .LANES(4), .L(8)) bus  ();
  vector_lane_sequencer_if #(.V(18), .LANES(4), .L(8)) bus2 ();

  vector_lane_sequencer #(.V(20), .LANES(4), .L(8)) dut  (.CLK(CLK), .RST(RST), .bus(bus));
  vector_lane_sequencer #(.V(18), .LANES(4), .L(8)) dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

  // Lane ALU model: 8-bit add per lane
  for (genvar j = 0; j < 4; j++) begin : g_lane
    assign bus.lane_result_i[j*8 +: 8]  = bus.lane_a_o[j*8 +: 8]  + bus.lane_b_o[j*8 +: 8];
    assign bus2.lane_result_i[j*8 +: 8] = bus2.lane_a_o[j*8 +: 8] + bus2.lane_b_o[j*8 +: 8];
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    logic [159:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a[i*8 +: 8] = 8'(i);
      b[i*8 +: 8] = 8'(2*i);
    end
    bus.rd1_vec_i = a; bus.rd2_vec_i = b; bus.op_type_i = 2'b01; bus.start_i = 1'b1;
    tick; bus.start_i = 1'b0;
    tick; tick;
    checks++; if (bus.chunk_o !== 3'd2) begin errors++; $display("FAIL reset_pre_chunk: got %0d expected 2", bus.chunk_o); end
    RST = 1'b1; tick; tick; RST = 1'b0;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done_o); end
    checks++; if (bus.chunk_o !== 3'd0) begin errors++; $display("FAIL reset_chunk: got %0d expected 0", bus.chunk_o); end
    checks++; if (bus.result_vec_o !== 160'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result_vec_o); end
    checks++; if (bus.lane_a_o !== 32'd0) begin errors++; $display("FAIL reset_lane_a: got %h expected 0", bus.lane_a_o); end
  endtask

  task automatic test_vector_vector;
    logic [159:0] a, b, exp;
    for (int i = 0; i < 20; i++) begin
      a[i*8 +: 8]   = 8'(i);
      b[i*8 +: 8]   = 8'(2*i);
      exp[i*8 +: 8] = 8'(3*i);
    end
    bus.rd1_vec_i = a; bus.rd2_vec_i = b; bus.op_type_i = 2'b01; bus.start_i = 1'b1;
    tick; bus.start_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++; if (bus.chunk_o !== 3'(c)) begin errors++; $display("FAIL vv_chunk%0d: got %0d expected %0d", c, bus.chunk_o, c); end
      checks++; if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0) begin errors++; $display("FAIL vv_busy%0d: got busy=%b done=%b expected 1/0", c, bus.busy_o, bus.done_o); end
      checks++; if (bus.lane_a_o[7:0] !== 8'(4*c) || bus.lane_b_o[7:0] !== 8'(8*c)) begin errors++; $display("FAIL vv_lane0_%0d: got a=%h b=%h expected %h/%h", c, bus.lane_a_o[7:0], bus.lane_b_o[7:0], 8'(4*c), 8'(8*c)); end
      tick;
    end
    checks++; if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b1) begin errors++; $display("FAIL vv_done: got done=%b busy=%b expected 1/1", bus.done_o, bus.busy_o); end
    checks++; if (bus.lane_a_o !== 32'd0) begin errors++; $display("FAIL vv_done_lanes: got %h expected 0", bus.lane_a_o); end
    tick;
    checks++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin errors++; $display("FAIL vv_after: got done=%b busy=%b expected 0/0", bus.done_o, bus.busy_o); end
    checks++; if (bus.result_vec_o !== exp) begin errors++; $display("FAIL vv_result: got %h expected %h", bus.result_vec_o, exp); end
  endtask

  task automatic test_vector_scalar;
    logic [159:0] a, exp;
    for (int i = 0; i < 20; i++) begin
      a[i*8 +: 8]   = 8'(10 + i);
      exp[i*8 +: 8] = 8'(15 + i);
    end
    bus.rd1_vec_i = a; bus.rd2_vec_i = {20{8'h77}}; bus.scalar_i = 8'h05;
    bus.op_type_i = 2'b10; bus.start_i = 1'b1;
    tick; bus.start_i = 1'b0;
    bus.rd1_vec_i = {20{8'hFF}}; bus.scalar_i = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      checks++; if (bus.lane_b_o !== {4{8'h05}}) begin errors++; $display("FAIL vs_lane_b%0d: got %h expected 05050505", c, bus.lane_b_o); end
      checks++; if (bus.lane_a_o[7:0] !== 8'(10 + 4*c)) begin errors++; $display("FAIL vs_lane_a%0d: got %h expected %h", c, bus.lane_a_o[7:0], 8'(10 + 4*c)); end
      tick;
    end
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL vs_done: got %b expected 1", bus.done_o); end
    tick;
    checks++; if (bus.result_vec_o !== exp) begin errors++; $display("FAIL vs_result: got %h expected %h", bus.result_vec_o, exp); end
  endtask

  task automatic test_scalar;
    logic [159:0] exp;
    for (int i = 0; i < 20; i++) exp[i*8 +: 8] = 8'(15 + i);
    bus.rd1_vec_i = {20{8'h3C}}; bus.op_type_i = 2'b00; bus.start_i = 1'b1;
    tick; bus.start_i = 1'b0;
    checks++; if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b1) begin errors++; $display("FAIL sc_cycle1: got busy=%b done=%b expected 1/1", bus.busy_o, bus.done_o); end
    checks++; if (bus.lane_a_o !== 32'd0 || bus.lane_b_o !== 32'd0) begin errors++; $display("FAIL sc_lanes: got a=%h b=%h expected 0/0", bus.lane_a_o, bus.lane_b_o); end
    tick;
    checks++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin errors++; $display("FAIL sc_cycle2: got busy=%b done=%b expected 0/0", bus.busy_o, bus.done_o); end
    checks++; if (bus.result_vec_o !== exp) begin errors++; $display("FAIL sc_result: got %h expected %h", bus.result_vec_o, exp); end
    bus.op_type_i = 2'b11; bus.start_i = 1'b1;
    tick; bus.start_i = 1'b0;
    checks++; if (bus.done_o !== 1'b1 || bus.chunk_o !== 3'd0) begin errors++; $display("FAIL sc_op11: got done=%b chunk=%0d expected 1/0", bus.done_o, bus.chunk_o); end
    tick;
  endtask

  task automatic test_flush;
    logic [159:0] a, exp;
    for (int i = 0; i < 20; i++) begin
      a[i*8 +: 8]   = 8'(i);
      exp[i*8 +: 8] = (i < 8) ? 8'(2*i) : 8'(15 + i);
    end
    bus.rd1_vec_i = a; bus.rd2_vec_i = a; bus.op_type_i = 2'b01; bus.start_i = 1'b1;
    tick; bus.start_i = 1'b0;
    tick; tick;
    checks++; if (bus.chunk_o !== 3'd2) begin errors++; $display("FAIL fl_chunk: got %0d expected 2", bus.chunk_o); end
    bus.flush_i = 1'b1;
    tick; bus.flush_i = 1'b0;
    checks++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.chunk_o !== 3'd0) begin errors++; $display("FAIL fl_idle: got busy=%b done=%b chunk=%0d expected 0/0/0", bus.busy_o, bus.done_o, bus.chunk_o); end
    tick;
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL fl_nodone: got %b expected 0", bus.done_o); end
    checks++; if (bus.result_vec_o !== exp) begin errors++; $display("FAIL fl_result: got %h expected %h", bus.result_vec_o, exp); end
    bus.start_i = 1'b1; bus.flush_i = 1'b1;
    tick; bus.start_i = 1'b0; bus.flush_i = 1'b0;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL fl_block_start: got busy=%b expected 0", bus.busy_o); end
    tick;
    checks++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin errors++; $display("FAIL fl_block_after: got busy=%b done=%b expected 0/0", bus.busy_o, bus.done_o); end
  endtask

  task automatic test_partial_chunk;
    logic [143:0] a, b, exp;
    for (int i = 0; i < 18; i++) begin
      a[i*8 +: 8]   = 8'(i + 1);
      b[i*8 +: 8]   = 8'd3;
      exp[i*8 +: 8] = 8'(i + 4);
    end
    bus2.rd1_vec_i = a; bus2.rd2_vec_i = b; bus2.op_type_i = 2'b01; bus2.start_i = 1'b1;
    tick;
    for (int c = 0; c < 5; c++) begin
      checks++; if (bus2.chunk_o !== 3'(c) || bus2.busy_o !== 1'b1) begin errors++; $display("FAIL pc_chunk%0d: got chunk=%0d busy=%b expected %0d/1", c, bus2.chunk_o, bus2.busy_o, c); end
      if (c == 4) begin
        checks++; if (bus2.lane_a_o !== {8'h00, 8'h00, 8'd18, 8'd17}) begin errors++; $display("FAIL pc_lane_a: got %h expected 00001211", bus2.lane_a_o); end
        checks++; if (bus2.lane_b_o !== {8'h00, 8'h00, 8'd3, 8'd3}) begin errors++; $display("FAIL pc_lane_b: got %h expected 00000303", bus2.lane_b_o); end
      end
      tick;
    end
    checks++; if (bus2.done_o !== 1'b1) begin errors++; $display("FAIL pc_done: got %b expected 1", bus2.done_o); end
    tick;
    checks++; if (bus2.busy_o !== 1'b0 || bus2.done_o !== 1'b0) begin errors++; $display("FAIL pc_idle7: got busy=%b done=%b expected 0/0", bus2.busy_o, bus2.done_o); end
    checks++; if (bus2.result_vec_o !== exp) begin errors++; $display("FAIL pc_result: got %h expected %h", bus2.result_vec_o, exp); end
    tick;
    checks++; if (bus2.busy_o !== 1'b1 || bus2.chunk_o !== 3'd0) begin errors++; $display("FAIL pc_restart: got busy=%b chunk=%0d expected 1/0", bus2.busy_o, bus2.chunk_o); end
    bus2.start_i = 1'b0; bus2.flush_i = 1'b1;
    tick; bus2.flush_i = 1'b0;
    checks++; if (bus2.busy_o !== 1'b0) begin errors++; $display("FAIL pc_flush: got busy=%b expected 0", bus2.busy_o); end
  endtask

  initial begin
    RST = 1'b1;
    bus.start_i = 1'b0;  bus.flush_i = 1'b0;  bus.op_type_i = 2'b00;
    bus.rd1_vec_i = '0;  bus.rd2_vec_i = '0;  bus.scalar_i = '0;
    bus2.start_i = 1'b0; bus2.flush_i = 1'b0; bus2.op_type_i = 2'b00;
    bus2.rd1_vec_i = '0; bus2.rd2_vec_i = '0; bus2.scalar_i = '0;
    tick; tick;
    RST = 1'b0;
    tick;
    test_reset;
    test_vector_vector;
    test_vector_scalar;
    test_scalar;
    test_flush;
    test_partial_chunk;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vector_lane_sequencer.md
Name: vector_lane_sequencer

Overview:
- Sequences one V-element vector operation through the LANES parallel 8-bit ALU lanes of the execute stage, one chunk of LANES elements per cycle.
- Captures the operands at start, drives the lane A/B inputs, gathers lane results into a full result vector, and reports busy/done to the control unit so the pipe registers can stall.
- Replaces the ad-hoc counter handshake between the fork and join logic with a single start/busy/done FSM.

Parameters:
- V, 20, elements per vector register
- LANES, 4, number of parallel lane ALUs
- L, 8, element width in bits

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  synchronous active-high reset
- start_i  input  1  request to begin an operation; sampled only in IDLE
- flush_i  input  1  pipeline clear; aborts any operation in progress
- op_type_i  input  2  00 scalar, 01 vector-vector, 10 vector-scalar, 11 reserved (treated as scalar)
- rd1_vec_i  input  V*L  operand vector A
- rd2_vec_i  input  V*L  operand vector B
- scalar_i  input  L  broadcast operand, used when op_type is 10
- lane_a_o  output  LANES*L  A inputs for the lanes of the current chunk
- lane_b_o  output  LANES*L  B inputs for the lanes of the current chunk
- lane_result_i  input  LANES*L  combinational lane ALU results for lane_a_o/lane_b_o
- result_vec_o  output  V*L  assembled result vector
- chunk_o  output  3  index of the current chunk, 0..NCHUNK-1
- busy_o  output  1  high in RUN and DONE
- done_o  output  1  one-cycle completion pulse

Behaviour:
- NCHUNK = ceil(V/LANES); the default is 5. chunk_o width is fixed at 3 bits, so NCHUNK must be 8 or less; elaboration fails otherwise.
- Reset (RST=1 at an edge): state=IDLE, chunk=0, captured operands=0, result_vec_o=0, lane_a_o=0, lane_b_o=0, busy_o=0, done_o=0. RST has priority over flush_i and start_i.
- States are IDLE, RUN and DONE.
- IDLE, with start_i=1 and op_type in {01,10}:
  - Capture rd1_vec_i, rd2_vec_i, scalar_i and the op type.
  - Set chunk=0 and go to RUN.
- IDLE, with start_i=1 and op_type in {00,11}: go to DONE with no capture; result_vec_o is unchanged.
- IDLE, with start_i=0: hold.
- RUN, lane drive (combinational from captured operands and chunk):
  - lane j gets element e = chunk*LANES + j.
  - lane_a_o[j] = A[e].
  - lane_b_o[j] = B[e] for op 01, or the captured scalar for op 10.
  - Lanes with e >= V drive 0.
- RUN, each edge:
  - result_vec_o[e] <= lane_result_i[j] for every lane with e < V; lanes with e >= V are discarded.
  - If chunk = NCHUNK-1, go to DONE; otherwise chunk <= chunk+1.
- Outside RUN, lane_a_o and lane_b_o are 0.
- DONE: done_o=1 for exactly one cycle, then go to IDLE with chunk=0. A start_i seen while in DONE is ignored.
- Latency, with the start edge counted as edge 0:
  - Vector op: RUN covers cycles 1..NCHUNK and done_o is high in cycle NCHUNK+1 (cycle 6 by default).
  - Scalar op: done_o is high in cycle 1.
- busy_o = (state != IDLE); done_o = (state == DONE). Both are registered-state decodes with no combinational path from inputs.
- start_i while busy is ignored; the operation in progress is not restarted.
- flush_i=1 in RUN or DONE: next state is IDLE, chunk=0, no done_o pulse. Partially written result elements remain in result_vec_o.
- flush_i=1 in IDLE: no effect, and it blocks a simultaneous start_i.
- result_vec_o holds its value between operations. Only elements written by a vector op change.

Test Plan:
- Reset: assert RST for 2 cycles mid-RUN (chunk=2) -> next cycle busy_o=0, done_o=0, chunk_o=0, result_vec_o=0.
- Vector-vector add: A[i]=i, B[i]=2i, lane model adds, start at cycle 0 -> chunk_o steps 0..4 in cycles 1..5, done_o=1 only in cycle 6, result_vec_o[i]=3i for i=0..19.
- Vector-scalar add: A[i]=10+i, scalar_i=5; change rd1_vec_i and scalar_i to 0xFF one cycle after start -> lane_b_o lanes all 0x05, result[i]=15+i (the captured operands are used).
- Scalar op 00 with start_i=1 -> busy_o high for 1 cycle, done_o=1 in cycle 1, lane outputs stay 0, result_vec_o unchanged.
- Flush and restart: start the vector op, pulse flush_i in cycle 3 -> IDLE next cycle, no done_o, elements 0..7 updated and 8..19 unchanged. Then assert start_i with flush_i=1 -> ignored.
- Partial chunk: V=18, LANES=4 -> NCHUNK=5, chunk 4 drives lanes 2 and 3 as 0, result elements 16..17 written, done_o in cycle 6. Also start_i held high throughout -> a new op begins only from IDLE (cycle 7).
